// File: rtl/scalar_fu_arbiter_if.sv
// Request, scalar-FU and response bundle for scalar_fu_arbiter.
// The slave modport is the arbiter side; master is requesters plus the FU.
interface scalar_fu_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ALUOP_WIDTH = 3
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_b;
    logic [NUM_REQ*ALUOP_WIDTH-1:0] req_aluop;
    logic [DATA_WIDTH-1:0]          fu_a;
    logic [DATA_WIDTH-1:0]          fu_b;
    logic [ALUOP_WIDTH-1:0]         fu_aluop;
    logic [2*DATA_WIDTH-1:0]        fu_out;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [ID_WIDTH-1:0]            rsp_id;
    logic [2*DATA_WIDTH-1:0]        rsp_data;
    logic                           rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_aluop, fu_out, rsp_ready,
        input  req_ready, fu_a, fu_b, fu_aluop, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_aluop, fu_out, rsp_ready,
        output req_ready, fu_a, fu_b, fu_aluop, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/scalar_fu_arbiter.sv
// Round-robin sharing of one combinational scalar FU among NUM_REQ requesters.
// Define SCALAR_FU_ARB_OPCHK_EN to reject aluop codes above RSH with rsp_err.
module scalar_fu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ALUOP_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    scalar_fu_arbiter_if.slave   bus
);
    localparam int ID_WIDTH  = $clog2(NUM_REQ);
    localparam int RES_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = ALUOP_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int step);
        int sum;
        sum = int'(base) + step;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return ID_WIDTH'(sum);
    endfunction

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DATA_WIDTH-1:0]   fu_a_q, fu_a_d;
    logic [DATA_WIDTH-1:0]   fu_b_q, fu_b_d;
    logic [ALUOP_WIDTH-1:0]  fu_aluop_q, fu_aluop_d;
    logic [RES_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    err_q, err_d;

    logic                    grant_found_s;
    logic [ID_WIDTH-1:0]     grant_idx_s;
    logic [ID_WIDTH-1:0]     cand_s;
    logic [DATA_WIDTH-1:0]   sel_a_s;
    logic [DATA_WIDTH-1:0]   sel_b_s;
    logic [ALUOP_WIDTH-1:0]  sel_aluop_s;
    logic                    illegal_s;
    logic [NUM_REQ-1:0]      req_ready_s;

    // Round-robin search from rr_ptr_q upward with wrap; first valid requester wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = wrap_add(rr_ptr_q, k);
            if (!grant_found_s && bus.req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Extract the granted requester's operand slices.
    always_comb begin
        sel_a_s     = '0;
        sel_b_s     = '0;
        sel_aluop_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == ID_WIDTH'(i)) begin
                sel_a_s     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b_s     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                sel_aluop_s = bus.req_aluop[i*ALUOP_WIDTH +: ALUOP_WIDTH];
            end else begin
                sel_a_s     = sel_a_s;
            end
        end
    end

`ifdef SCALAR_FU_ARB_OPCHK_EN
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MAX = ALUOP_WIDTH'(4);
    assign illegal_s = (sel_aluop_s > ALUOP_MAX);
`else
    assign illegal_s = 1'b0;
`endif

    // Next-state and grant logic; every register holds unless its state updates it.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_aluop_d  = fu_aluop_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        req_ready_s = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    id_d     = grant_idx_s;
                    rr_ptr_d = wrap_add(grant_idx_s, 1);
                    err_d    = illegal_s;
                    if (illegal_s) begin
                        fu_a_d     = '0;
                        fu_b_d     = '0;
                        fu_aluop_d = ALUOP_ADD;
                    end else begin
                        fu_a_d     = sel_a_s;
                        fu_b_d     = sel_b_s;
                        fu_aluop_d = sel_aluop_s;
                    end
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // An illegal op reports zero rather than whatever the FU makes of ADD 0,0.
                if (err_q) begin
                    rsp_data_d = '0;
                end else begin
                    rsp_data_d = bus.fu_out;
                end
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_aluop_q  <= ALUOP_ADD;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_aluop_q  <= fu_aluop_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.fu_a      = fu_a_q;
    assign bus.fu_b      = fu_b_q;
    assign bus.fu_aluop  = fu_aluop_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef SCALAR_FU_ARB_OPCHK_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_scalar_fu_arbiter.sv
// Directed bench for scalar_fu_arbiter: stimulus pushes expected responses, a monitor pops them.
// The bench also models the combinational scalar FU.
module tb_scalar_fu_arbiter;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SNA = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_LSH = 3'd3;
    localparam logic [2:0] OP_RSH = 3'd4;

`ifdef SCALAR_FU_ARB_OPCHK_EN
    localparam logic [15:0] ILL_DATA  = 16'h0000;
    localparam logic        ILL_ERR   = 1'b1;
    localparam logic [2:0]  ILL_ALUOP = 3'd0;
    localparam logic [7:0]  ILL_A     = 8'd0;
`else
    localparam logic [15:0] ILL_DATA  = 16'hDEAD;
    localparam logic        ILL_ERR   = 1'b0;
    localparam logic [2:0]  ILL_ALUOP = 3'd6;
    localparam logic [7:0]  ILL_A     = 8'd9;
`endif

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;
    logic [15:0] exp_c [4] = '{16'h0007, 16'hFFFE, 16'hFFE8, 16'h0010};

    scalar_fu_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ALUOP_WIDTH(3)) bus ();

    scalar_fu_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ALUOP_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] fu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        logic signed [15:0] ea, eb;
        ea = {{8{a[7]}}, a};
        eb = {{8{b[7]}}, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea * eb;
            3'd3:    return ea <<< b[3:0];
            3'd4:    return ea >>> b[3:0];
            default: return 16'hDEAD;
        endcase
    endfunction

    assign bus.fu_out = fu_model(bus.fu_a, bus.fu_b, bus.fu_aluop);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input logic [3:0] exp, input string name);
        #2;
        check(name, 32'(bus.req_ready), 32'(exp));
    endtask

    task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        bus.req_a[idx*8 +: 8]     = a;
        bus.req_b[idx*8 +: 8]     = b;
        bus.req_aluop[idx*3 +: 3] = op;
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] data, input logic err);
        exp_q.push_back('{id, data, err});
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_fu_a"},      32'(bus.fu_a),      32'd0);
        check({tag, "_fu_b"},      32'(bus.fu_b),      32'd0);
        check({tag, "_fu_aluop"},  32'(bus.fu_aluop),  32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
        check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    endtask

    // Response monitor: every accepted response must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h, required no response",
                         bus.rsp_id, bus.rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id",   32'(bus.rsp_id),   32'(mon_e.id));
                check("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                check("rsp_err",  32'(bus.rsp_err),  32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_aluop = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Single request from 2: 5 * -3 = -15
        set_req(2, 8'd5, 8'hFD, OP_MUL);
        bus.req_valid = 4'b0100;
        chk_ready(4'b0100, "single_grant");
        push(2'd2, 16'hFFF1, 1'b0);
        tick();
        bus.req_valid = '0;
        #2;
        check("exec_fu_a",     32'(bus.fu_a),      32'h05);
        check("exec_fu_b",     32'(bus.fu_b),      32'hFD);
        check("exec_fu_aluop", 32'(bus.fu_aluop),  32'(OP_MUL));
        check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        tick();

        // Contention from reset: grants 0,1,2,3 three cycles apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 8'd3,  8'd4,  OP_ADD);
        set_req(1, 8'd10, 8'd12, OP_SNA);
        set_req(2, 8'hFC, 8'd6,  OP_MUL);
        set_req(3, 8'd1,  8'd4,  OP_LSH);
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            chk_ready(4'b0001 << g, "rr_grant");
            push(2'(g), exp_c[g], 1'b0);
            tick();
            chk_ready(4'b0000, "exec_no_grant");
            tick();
            chk_ready(4'b0000, "resp_no_grant");
            tick();
        end

        // Wrap-around: requests 1 and 3 after grant to 3
        set_req(1, 8'h80, 8'h80, OP_MUL);
        set_req(3, 8'hF0, 8'd2,  OP_RSH);
        bus.req_valid = 4'b1010;
        chk_ready(4'b0010, "wrap_grant1");
        push(2'd1, 16'h4000, 1'b0);
        tick();
        tick();
        tick();
        chk_ready(4'b1000, "wrap_grant3");
        push(2'd3, 16'hFFFC, 1'b0);
        tick();
        bus.req_valid = '0;
        tick();
        tick();

        // Backpressure with requester 0 pending
        bus.rsp_ready = 1'b0;
        set_req(2, 8'd7, 8'd7, OP_ADD);
        set_req(0, 8'd2, 8'd3, OP_MUL);
        bus.req_valid = 4'b0100;
        chk_ready(4'b0100, "bp_grant2");
        push(2'd2, 16'h000E, 1'b0);
        tick();
        bus.req_valid = 4'b0001;
        chk_ready(4'b0000, "bp_exec_ready");
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_id",    32'(bus.rsp_id),    32'd2);
            check("bp_rsp_data",  32'(bus.rsp_data),  32'h000E);
            chk_ready(4'b0000, "bp_ready");
            tick();
        end
        bus.rsp_ready = 1'b1;
        chk_ready(4'b0000, "bp_handshake_ready");
        tick();
        chk_ready(4'b0001, "bp_grant0");
        push(2'd0, 16'h0006, 1'b0);
        tick();
        bus.req_valid = '0;
        tick();
        tick();

        // Reset during EXEC discards the op and clears rr_ptr
        set_req(1, 8'd1, 8'd1, OP_ADD);
        bus.req_valid = 4'b0010;
        chk_ready(4'b0010, "pre_reset_grant1");
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0;
        set_req(3, 8'd5, 8'd2, OP_LSH);
        bus.req_valid = 4'b1000;
        chk_ready(4'b1000, "post_reset_grant3");
        push(2'd3, 16'h0014, 1'b0);
        tick();
        bus.req_valid = '0;
        tick();
        tick();

        // Illegal aluop 6 from requester 1
        set_req(1, 8'd9, 8'd9, 3'd6);
        bus.req_valid = 4'b0010;
        chk_ready(4'b0010, "ill_grant1");
        push(2'd1, ILL_DATA, ILL_ERR);
        tick();
        bus.req_valid = '0;
        #2;
        check("ill_fu_aluop", 32'(bus.fu_aluop), 32'(ILL_ALUOP));
        check("ill_fu_a",     32'(bus.fu_a),     32'(ILL_A));
        tick();
        check("ill_rsp_err",  32'(bus.rsp_err),  32'(ILL_ERR));
        tick();

        // rr_ptr advanced past 1 regardless of the illegal op
        set_req(2, 8'hFF, 8'hFF, OP_MUL);
        set_req(0, 8'h7F, 8'h01, OP_SNA);
        bus.req_valid = 4'b0101;
        chk_ready(4'b0100, "post_ill_grant2");
        push(2'd2, 16'h0001, 1'b0);
        tick();
        tick();
        tick();
        chk_ready(4'b0001, "post_ill_grant0");
        push(2'd0, 16'h007E, 1'b0);
        tick();
        bus.req_valid = '0;
        tick();
        tick();

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
            tick();
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scalar_fu_arbiter.md
# scalar_fu_arbiter

Round-robin arbiter and sequencer that shares one combinational scalar function unit (ADD/SNA/MUL/LSH/RSH) among NUM_REQ requesters inside an IMA. It accepts one operation at a time through per-requester valid/ready handshakes and drives registered operands and aluop into the scalar FU. It captures the 2*DATA_WIDTH signed result and returns it on a single response channel, tagged with the requester index.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, operand width; result width is 2*DATA_WIDTH
- ALUOP_WIDTH, 3, aluop encoding width (ADD=0, SNA=1, MUL=2, LSH=3, RSH=4)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_a, req_b  in  NUM_REQ*DATA_WIDTH  flattened signed operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_aluop  in  NUM_REQ*ALUOP_WIDTH  flattened aluop per requester
- fu_a, fu_b  out  DATA_WIDTH  registered operands to the scalar FU
- fu_aluop  out  ALUOP_WIDTH  registered aluop to the scalar FU
- fu_out  in  2*DATA_WIDTH  signed FU result (combinational from fu_a/fu_b/fu_aluop)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns rsp_data
- rsp_data  out  2*DATA_WIDTH  captured signed result
- rsp_err  out  1  illegal aluop flag (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, pick grant g by round-robin: search from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - Assert req_ready[g] combinationally in the same cycle.
  - Latch slice g of req_a, req_b and req_aluop into fu_a, fu_b and fu_aluop; latch g into the id register.
  - Set rr_ptr = (g+1) mod NUM_REQ, then go to EXEC.
  - With no valid, stay in IDLE; req_ready is all zero.
- EXEC: capture fu_out into rsp_data; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable.
  - On rsp_ready=1, go to IDLE.
  - Otherwise stay in RESP indefinitely. No new grant is issued and fu_* are held.
- req_ready is zero in EXEC and RESP. At most one bit of req_ready is set in any cycle.
- A requester may drop req_valid before it is granted. The arbiter evaluates only the current cycle's req_valid.
- The result is stored at full 2*DATA_WIDTH with no truncation. The FU owns sign extension.

## Timing
- Grant handshake in cycle T. fu_* are valid from T+1 (EXEC). rsp_valid rises at T+2.
- With rsp_ready held high, back-to-back grants occur every 3 cycles (T, T+3, ...).
- Reset values: req_ready=0, fu_a=0, fu_b=0, fu_aluop=0 (ADD), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr_ptr=0, state=IDLE.
- Reset asserted in any state returns the block to IDLE on the next edge. An in-flight or pending response is discarded and is not delivered.
- req_valid arriving in the same cycle as the RESP handshake is not granted until the following IDLE cycle.

## Configuration
- SCALAR_FU_ARB_OPCHK_EN defined:
  - At grant, an aluop greater than 4 marks the op illegal.
  - fu_aluop is driven 0 (ADD) and fu_a/fu_b are driven 0.
  - The response carries rsp_err=1 and rsp_data=0.
  - Timing is unchanged; the rr_ptr update is unchanged.
- Not defined: aluop is passed through unchecked, and rsp_err is tied to 0.

## Test plan
- Single request: req_valid[2]=1, a=5, b=-3, aluop=MUL.
  - Expect req_ready=4'b0100 in the same cycle.
  - rsp_valid 2 cycles later with rsp_id=2, rsp_data=-15 (16'hFFF1).
- Contention: all four valid from reset, rsp_ready=1.
  - Grants in order 0,1,2,3 at cycles T, T+3, T+6, T+9; rsp_id follows the same order.
- Wrap-around: after a grant to 3, raise requests 1 and 3.
  - Next grant goes to 1 (search wraps to 0 first), then 3.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid[0]=1 pending.
  - rsp_valid/rsp_data/rsp_id are stable and req_ready=0 throughout.
  - Grant to 0 occurs in the IDLE cycle after rsp_ready=1.
- Reset mid-operation: assert rst in EXEC.
  - Next cycle: all outputs at reset values, no response delivered.
  - A subsequent request from 3 is granted first (rr_ptr=0 search reaches 3).
- With SCALAR_FU_ARB_OPCHK_EN, aluop=6 from requester 1:
  - rsp_err=1, rsp_data=0, rsp_id=1, fu_aluop=0 during EXEC.
- Without the macro: rsp_err stays 0.
